// File: rtl/cby_param_cfg_pkg.sv
// cby_param_pkg: shared controller state encoding and elaboration-time helpers
package cby_param_pkg;
   typedef enum logic [1:0] {EMPTY, SHIFTING, READY} state_e;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   function automatic int tap_index(input int p, input int j, input int step, input int width);
      return (p + (j / 2) * step) % width;
   endfunction
endpackage

// File: rtl/cby_param_cfg_if.sv
// cby_param_cfg_if: serial configuration chain and status of the connection block
interface cby_param_cfg_if;
   logic ccff_head;
   logic ccff_en;
   logic cfg_commit;
   logic ccff_tail;
   logic cfg_loaded;
   logic cfg_error;
   modport master (output ccff_head, ccff_en, cfg_commit, input ccff_tail, cfg_loaded, cfg_error);
   modport slave (input ccff_head, ccff_en, cfg_commit, output ccff_tail, cfg_loaded, cfg_error);
endinterface

// File: rtl/cby_param_cfg_mux.sv
// cby_param_mux: one ipin selector; out-of-range selects drive 0
module cby_param_mux #(
   parameter int MUX_SIZE = 6,
   parameter int SEL_W    = 3
) (
   input  logic [MUX_SIZE-1:0] in_i,
   input  logic [SEL_W-1:0]    sel_i,
   output logic                out_o
);
   assign out_o = ({1'b0, sel_i} < (SEL_W+1)'(MUX_SIZE)) ? in_i[sel_i] : 1'b0;
endmodule

// File: rtl/cby_param_cfg.sv
// cby_param_cfg: vertical connection block with double-buffered serial config
module cby_param_cfg
   import cby_param_pkg::*;
#(
   parameter int CHAN_WIDTH = 9,
   parameter int N_LEFT     = 2,
   parameter int N_RIGHT    = 3,
   parameter int MUX_SIZE   = 6,
   parameter int TAP_STEP   = 4,
   parameter int REG_IPIN   = 0
) (
   input  logic                  prog_clk,
   input  logic                  prog_reset,
   input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
   input  logic [CHAN_WIDTH-1:0] chany_top_in,
   output logic [CHAN_WIDTH-1:0] chany_bottom_out,
   output logic [CHAN_WIDTH-1:0] chany_top_out,
   output logic [N_LEFT-1:0]     ipin_left,
   output logic [N_RIGHT-1:0]    ipin_right,
   cby_param_cfg_if.slave        cfg
);
   localparam int SEL_W    = clog2(MUX_SIZE);
   localparam int N_PIN    = N_LEFT + N_RIGHT;
   localparam int CFG_BITS = N_PIN * SEL_W;
   localparam int CNT_W    = clog2(CFG_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

   state_e              state_q, state_d;
   logic [CFG_BITS-1:0] shadow_q, shadow_d, active_q, active_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                tail_q, tail_d, loaded_q, loaded_d, error_q, error_d;
   logic [N_PIN-1:0]    mux_out, pin_c, pin;

   assign chany_top_out    = chany_bottom_in;
   assign chany_bottom_out = chany_top_in;

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_q  <= EMPTY;
         shadow_q <= '0;
         active_q <= '0;
         cnt_q    <= '0;
         tail_q   <= 1'b0;
         loaded_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         cnt_q    <= cnt_d;
         tail_q   <= tail_d;
         loaded_q <= loaded_d;
         error_q  <= error_d;
      end
   end

   // commit outranks shift; a bad commit falls back to whatever config was live
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      active_d = active_q;
      cnt_d    = cnt_q;
      tail_d   = tail_q;
      loaded_d = loaded_q;
      error_d  = error_q;
      if (cfg.cfg_commit) begin
         cnt_d = '0;
         if (cnt_q == CNT_FULL) begin
            active_d = shadow_q;
            loaded_d = 1'b1;
            error_d  = 1'b0;
            state_d  = READY;
         end else begin
            error_d = 1'b1;
            state_d = loaded_q ? READY : EMPTY;
         end
      end else if (cfg.ccff_en) begin
         shadow_d = {shadow_q[CFG_BITS-2:0], cfg.ccff_head};
         tail_d   = shadow_q[CFG_BITS-1];
         cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
         state_d  = SHIFTING;
      end
   end

   assign cfg.ccff_tail  = tail_q;
   assign cfg.cfg_loaded = loaded_q;
   assign cfg.cfg_error  = error_q;

   for (genvar p = 0; p < N_PIN; p++) begin : g_pin
      logic [MUX_SIZE-1:0] mux_in;
      for (genvar j = 0; j < MUX_SIZE; j++) begin : g_in
         localparam int T = tap_index(p, j, TAP_STEP, CHAN_WIDTH);
         assign mux_in[j] = (j % 2 == 0) ? chany_bottom_in[T] : chany_top_in[T];
      end
      cby_param_mux #(.MUX_SIZE(MUX_SIZE), .SEL_W(SEL_W)) u_mux (
         .in_i  (mux_in),
         .sel_i (active_q[p*SEL_W +: SEL_W]),
         .out_o (mux_out[p])
      );
   end

   assign pin_c = {N_PIN{loaded_q}} & mux_out;

   if (REG_IPIN != 0) begin : g_reg
      logic [N_PIN-1:0] pin_q;
      always_ff @(posedge prog_clk) pin_q <= prog_reset ? '0 : pin_c;
      assign pin = pin_q;
   end else begin : g_comb
      assign pin = pin_c;
   end

   assign ipin_left  = pin[N_LEFT-1:0];
   assign ipin_right = pin[N_PIN-1:N_LEFT];
endmodule

// File: tb/tb_cby_param_cfg.sv
// tb_cby_param_cfg: combinational and registered-ipin instances against a behavioural model
module tb_cby_param_cfg;
   localparam int CW = 9, NL = 2, NR = 3, NP = 5, CB = 15;

   logic prog_clk = 1'b0, prog_reset = 1'b1;
   logic [CW-1:0] bot = '0, top = '0;
   logic head = 1'b0, en = 1'b0, commit = 1'b0;
   logic [CW-1:0] bo0, to0, bo1, to1;
   logic [NL-1:0] il0, il1;
   logic [NR-1:0] ir0, ir1;

   cby_param_cfg_if c0 ();
   cby_param_cfg_if c1 ();
   assign c0.ccff_head = head;
   assign c0.ccff_en = en;
   assign c0.cfg_commit = commit;
   assign c1.ccff_head = head;
   assign c1.ccff_en = en;
   assign c1.cfg_commit = commit;

   cby_param_cfg u_comb (
      .prog_clk(prog_clk), .prog_reset(prog_reset),
      .chany_bottom_in(bot), .chany_top_in(top),
      .chany_bottom_out(bo0), .chany_top_out(to0),
      .ipin_left(il0), .ipin_right(ir0), .cfg(c0)
   );
   cby_param_cfg #(.REG_IPIN(1)) u_reg (
      .prog_clk(prog_clk), .prog_reset(prog_reset),
      .chany_bottom_in(bot), .chany_top_in(top),
      .chany_bottom_out(bo1), .chany_top_out(to1),
      .ipin_left(il1), .ipin_right(ir1), .cfg(c1)
   );

   always #5 prog_clk = ~prog_clk;

   int errors = 0, checks = 0;
   logic [CB-1:0] m_shadow = '0, m_active = '0;
   int m_cnt = 0;
   logic m_tail = 1'b0, m_loaded = 1'b0, m_error = 1'b0;
   logic [NP-1:0] exp_q[$];

   typedef struct {logic [CW-1:0] b; logic [CW-1:0] t;} pt_t;
   typedef struct {logic [CW-1:0] b; logic [CW-1:0] t; logic [NL-1:0] el; logic [NR-1:0] er;} vec_t;
   pt_t pv[6];
   vec_t tv[8];
   logic [CB-1:0] cfg_c, pat_a, pat_b, cfg_d;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [NP-1:0] model_pins(input logic [CW-1:0] b, input logic [CW-1:0] t);
      logic [NP-1:0] r;
      r = '0;
      for (int p = 0; p < NP; p++) begin
         int s;
         int tr;
         s = int'(m_active[p*3 +: 3]);
         tr = (p + (s / 2) * 4) % CW;
         if (m_loaded && s < 6) r[p] = (s % 2 == 1) ? t[tr] : b[tr];
      end
      return r;
   endfunction

   task automatic step();
      exp_q.push_back(prog_reset ? '0 : model_pins(bot, top));
      @(posedge prog_clk);
      if (prog_reset) begin
         m_shadow = '0; m_active = '0; m_cnt = 0; m_tail = 0; m_loaded = 0; m_error = 0;
      end else if (commit) begin
         if (m_cnt == CB) begin
            m_active = m_shadow; m_loaded = 1; m_error = 0;
         end else m_error = 1;
         m_cnt = 0;
      end else if (en) begin
         m_tail = m_shadow[CB-1];
         m_shadow = {m_shadow[CB-2:0], head};
         if (m_cnt < CB + 1) m_cnt++;
      end
      @(negedge prog_clk);
      chk("ipin_comb", {ir0, il0}, model_pins(bot, top));
      chk("ipin_reg", {ir1, il1}, exp_q.pop_front());
      chk("tail", c0.ccff_tail, m_tail);
      chk("loaded", c0.cfg_loaded, m_loaded);
      chk("error", c0.cfg_error, m_error);
      chk("tail_r", c1.ccff_tail, m_tail);
      chk("loaded_r", c1.cfg_loaded, m_loaded);
      chk("error_r", c1.cfg_error, m_error);
      chk("pass", {bo0, to0, bo1, to1}, {top, bot, top, bot});
   endtask

   task automatic shift_bits(input logic [CB-1:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         head = v[i];
         en = 1'b1;
         step();
      end
      en = 1'b0;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      step();
      commit = 1'b0;
   endtask

   initial begin
      step();
      step();
      chk("rst_loaded", c0.cfg_loaded, 0);
      chk("rst_ipins_r", {ir1, il1}, 0);
      for (int i = 0; i < 6; i++) begin
         pv[i].b = CW'($urandom);
         pv[i].t = CW'($urandom);
      end
      for (int i = 0; i < 6; i++) begin
         prog_reset = (i < 3);
         bot = pv[i].b;
         top = pv[i].t;
         #1;
         chk("pass_top", to0, pv[i].b);
         chk("pass_bot", bo0, pv[i].t);
         step();
      end
      prog_reset = 1'b0;
      // pin4 sel 7, pin3 sel 5, pin2 sel 1, pin1 sel 3, pin0 sel 2
      cfg_c = {3'd7, 3'd5, 3'd1, 3'd3, 3'd2};
      shift_bits(cfg_c, 15);
      do_commit();
      chk("full_loaded", c0.cfg_loaded, 1);
      bot = '0;
      top = '1;
      #1 chk("pin0_lo", il0[0], 0);
      bot = 9'h010;
      #1 chk("pin0_hi", il0[0], 1);
      bot = '1;
      #1 chk("sel7_zero", ir0[2], 0);
      step();
      for (int i = 0; i < 8; i++) begin
         tv[i].b = CW'($urandom);
         tv[i].t = CW'($urandom);
         {tv[i].er, tv[i].el} = model_pins(tv[i].b, tv[i].t);
      end
      for (int i = 0; i < 8; i++) begin
         bot = tv[i].b;
         top = tv[i].t;
         #1;
         chk("vec_left", il0, tv[i].el);
         chk("vec_right", ir0, tv[i].er);
         step();
      end
      bot = '0;
      step();
      bot = 9'h010;
      #1 chk("reg_hold", il1[0], 0);
      step();
      chk("reg_upd", il1[0], 1);
      pat_a = CB'($urandom);
      pat_b = CB'($urandom);
      shift_bits(pat_a, 15);
      for (int i = CB - 1; i >= 0; i--) begin
         head = pat_b[i];
         en = 1'b1;
         step();
         chk("tail_delay", c0.ccff_tail, pat_a[i]);
      end
      en = 1'b0;
      do_commit();
      chk("long_err", c0.cfg_error, 1);
      chk("long_keep", c0.cfg_loaded, 1);
      cfg_d = {3'd0, 3'd4, 3'd6, 3'd1, 3'd5};
      shift_bits(cfg_d, 15);
      en = 1'b1;
      head = ~pat_b[0];
      commit = 1'b1;
      step();
      commit = 1'b0;
      en = 1'b0;
      chk("cmt_tail_hold", c0.ccff_tail, pat_b[0]);
      chk("cmt_err_clr", c0.cfg_error, 0);
      for (int i = 0; i < 4; i++) begin
         bot = CW'($urandom);
         top = CW'($urandom);
         step();
      end
      prog_reset = 1'b1;
      step();
      prog_reset = 1'b0;
      shift_bits(cfg_c, 14);
      do_commit();
      chk("short_err", c0.cfg_error, 1);
      chk("short_unloaded", c0.cfg_loaded, 0);
      chk("short_pins", {ir0, il0}, 0);
      shift_bits(cfg_c, 15);
      do_commit();
      shift_bits(cfg_d, 7);
      prog_reset = 1'b1;
      commit = 1'b1;
      en = 1'b1;
      step();
      prog_reset = 1'b0;
      commit = 1'b0;
      en = 1'b0;
      chk("mid_rst_loaded", c1.cfg_loaded, 0);
      chk("mid_rst_pins", {ir1, il1}, 0);
      do_commit();
      chk("mid_rst_cnt", c0.cfg_error, 1);
      shift_bits(cfg_d, 15);
      do_commit();
      for (int i = 0; i < 4; i++) begin
         bot = CW'($urandom);
         top = CW'($urandom);
         step();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cby_param_cfg.md
CBY_PARAM_CFG -- requirements
Module: cby_param_cfg

Interface
REQ-001 SHALL have parameter CHAN_WIDTH, default 9, tracks per direction.
REQ-002 SHALL have parameter N_LEFT, default 2, number of right-grid (left-side) ipins.
REQ-003 SHALL have parameter N_RIGHT, default 3, number of left-grid (right-side) ipins.
REQ-004 SHALL have parameter MUX_SIZE, default 6, inputs per ipin mux (even, >=2).
REQ-005 SHALL have parameter TAP_STEP, default 4, track stride between tap pairs.
REQ-006 SHALL have parameter REG_IPIN, default 0, 1 = registered ipin outputs.
REQ-007 SHALL have port prog_clk, input, 1, the single clock.
REQ-008 SHALL have port prog_reset, input, 1, reset; synchronous, active-high.
REQ-009 SHALL have port chany_bottom_in, input, CHAN_WIDTH, tracks entering from the bottom.
REQ-010 SHALL have port chany_top_in, input, CHAN_WIDTH, tracks entering from the top.
REQ-011 SHALL have port ccff_head, input, 1, config serial data in.
REQ-012 SHALL have port ccff_en, input, 1, shift enable.
REQ-013 SHALL have port cfg_commit, input, 1, single-cycle commit strobe.
REQ-014 SHALL have port chany_bottom_out, output, CHAN_WIDTH, tracks leaving at the bottom.
REQ-015 SHALL have port chany_top_out, output, CHAN_WIDTH, tracks leaving at the top.
REQ-016 SHALL have port ipin_left, output, N_LEFT, right-grid ipins.
REQ-017 SHALL have port ipin_right, output, N_RIGHT, left-grid ipins.
REQ-018 SHALL have port ccff_tail, output, 1, config serial data out, registered.
REQ-019 SHALL have port cfg_loaded, output, 1, active config valid.
REQ-020 SHALL have port cfg_error, output, 1, sticky flag for a short/long load.

Function
REQ-021 Pass-through SHALL be combinational: chany_top_out = chany_bottom_in and chany_bottom_out = chany_top_in.
REQ-022 Ipin index p SHALL be p = k for ipin_left[k] and p = N_LEFT + k for ipin_right[k].
REQ-023 Mux input j of ipin p SHALL be track t = (p + (j/2)*TAP_STEP) mod CHAN_WIDTH, taken from chany_bottom_in when j is even and chany_top_in when j is odd.
REQ-024 SEL_W SHALL be clog2(MUX_SIZE) and CFG_BITS SHALL be (N_LEFT+N_RIGHT)*SEL_W.
REQ-025 Ipin p select SHALL be active[p*SEL_W +: SEL_W]; a select value >= MUX_SIZE SHALL drive 0.
REQ-026 When ccff_en=1 and cfg_commit=0, on prog_clk: shadow <= {shadow[CFG_BITS-2:0], ccff_head}, ccff_tail <= shadow[CFG_BITS-1], and cnt increments, saturating at CFG_BITS+1.
REQ-027 On cfg_commit with cnt == CFG_BITS: active <= shadow, cnt <= 0, cfg_loaded <= 1, cfg_error <= 0.
REQ-028 On cfg_commit with cnt != CFG_BITS: active and cfg_loaded SHALL be unchanged, cfg_error <= 1, cnt <= 0.
REQ-029 When cfg_commit and ccff_en are high together, commit SHALL win: the shift is suppressed and shadow and ccff_tail hold.
REQ-030 Shifting SHALL NOT disturb active, so ipins keep routing during reload.
REQ-031 While cfg_loaded=0, all ipin outputs SHALL be 0.
REQ-032 REG_IPIN=0: ipin outputs SHALL be combinational, 0-cycle latency; REG_IPIN=1: they SHALL be registered on prog_clk, 1-cycle latency from tracks or active change.
REQ-033 Controller states SHALL be EMPTY (no valid config), SHIFTING (cnt>0), READY (cfg_loaded=1, cnt=0); SHIFTING SHALL return to READY on a good commit, or to the prior EMPTY/READY state on a bad commit.

Reset
REQ-034 When prog_reset=1 on prog_clk: shadow=0, active=0, cnt=0, ccff_tail=0, cfg_loaded=0, cfg_error=0, registered ipins=0, state EMPTY.
REQ-035 Reset mid-shift or coincident with commit SHALL take priority and discard the partial load.
REQ-036 Pass-through outputs SHALL be unaffected by reset.

Structure
REQ-037 Package cby_param_pkg SHALL hold the state enum and the functions clog2 and tap_index(p, j).
REQ-038 A single sub-module cby_param_mux (MUX_SIZE, SEL_W; in, sel, out) SHALL be instantiated once per ipin; the config chain and FSM SHALL stay in the top level.

Verification (defaults, CFG_BITS=15)
REQ-039 Pass-through: drive random chany_bottom_in/chany_top_in -> outputs match in the same cycle, including under reset.
REQ-040 Full load: shift 15 bits so that ipin_left[0] sel=2, then commit -> cfg_loaded=1; ipin_left[0] = chany_bottom_in[4]; toggling it toggles the pin.
REQ-041 Short load: shift 14 bits, then commit -> cfg_error=1, cfg_loaded stays 0, ipins stay 0.
REQ-042 ccff_tail: shift a 15-bit pattern followed by 15 more bits -> ccff_tail reproduces the first pattern delayed by 15 shifts.
REQ-043 Commit with ccff_en high -> shift suppressed, ccff_tail unchanged; sel=7 on any pin -> that output is 0.
REQ-044 REG_IPIN=1: a track change -> the ipin updates exactly 1 prog_clk later; prog_reset mid-load -> all state returns to its reset values.
